// File: rtl/ysyx_22040125_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_pkg
// Shared constants for the RV64 5-stage pipeline front end.
//   XLEN     : address / PC width
//   ILEN     : instruction width
//   RESET_PC : first fetch address after reset
//   INST_NOP : canonical NOP (addi x0, x0, 0), driven on out_inst when idle
// ----------------------------------------------------------------------------
package ysyx_22040125_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned ILEN     = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22040125_ifq_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_ifq_fifo
// Synchronous ring buffer with combinational head read.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : empties the buffer (takes precedence over push/pop)
//   i_push     : write i_wdata at tail (ignored when full unless popping)
//   i_pop      : drop the head entry (ignored when empty)
//   o_rdata    : head entry
//   o_count    : number of valid entries, 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally).
// ----------------------------------------------------------------------------
module ysyx_22040125_ifq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ysyx_22040125_ifu_queue.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_ifu_queue
// Instruction-fetch unit with a DEPTH-entry prefetch queue. Issues sequential
// in-order fetches to a variable-latency instruction memory, buffers returned
// instructions and hands them to ID over valid/ready. A redirect flushes the
// queue and discards every response still in flight.
//   clk, rst                        : clock, synchronous active-high reset
//   redirect_valid, redirect_pc     : restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/inst             : in-order response channel, no backpressure
//   out_valid/ready, out_inst/pc    : instruction toward ID
// Optional feature macro: YSYX_22040125_IFQ_BYPASS_EN
//   defined   -> a response arriving to an empty queue is presented to ID in
//                the same cycle (combinational rsp -> out path)
//   undefined -> every response is registered in the queue first
// ----------------------------------------------------------------------------
module ysyx_22040125_ifu_queue
  import ysyx_22040125_pkg::INST_NOP;
#(
  parameter int unsigned     XLEN     = ysyx_22040125_pkg::XLEN,
  parameter int unsigned     ILEN     = ysyx_22040125_pkg::ILEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_22040125_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_qcount;
  logic [CW-1:0]   w_live;
  logic [CW:0]     w_occupancy;
  logic            w_q_empty;
  logic            w_issue;
  logic            w_rsp;
  logic            w_rsp_drop;
  logic            w_rsp_keep;
  logic            w_deq;
  logic            w_q_push;
  logic            w_q_pop;
  logic [XLEN-1:0] w_rsp_pc;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_inst;
  logic            w_unused_pc_lo;

  assign w_unused_pc_lo = ^redirect_pc[1:0];

  // Credit: every live (non-discarded) request already owns a queue slot, so
  // a response can always be written without backpressure.
  assign w_live      = w_inflight - r_drop;
  assign w_occupancy = {1'b0, w_qcount} + {1'b0, w_live};
  assign w_q_empty   = (w_qcount == '0);

  assign imem_req_valid = !rst && !redirect_valid && (w_occupancy < DEPTH_C);
  assign imem_req_addr  = r_fetch_pc;
  assign w_issue        = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are a protocol violation and ignored.
  assign w_rsp      = imem_rsp_valid && (w_inflight != '0);
  assign w_rsp_drop = w_rsp && ((r_drop != '0) || redirect_valid);
  assign w_rsp_keep = w_rsp && !w_rsp_drop;

`ifdef YSYX_22040125_IFQ_BYPASS_EN
  logic w_bypass;

  // w_rsp_keep already excludes a same-cycle redirect.
  assign w_bypass  = w_rsp_keep && w_q_empty && !rst;
  assign out_valid = !rst && !redirect_valid && (!w_q_empty || w_bypass);
  assign out_inst  = !w_q_empty ? w_head_inst : (w_bypass ? imem_rsp_inst : INST_NOP);
  assign out_pc    = !w_q_empty ? w_head_pc : w_rsp_pc;
  assign w_deq     = out_valid && out_ready;
  assign w_q_push  = w_rsp_keep && !(w_bypass && out_ready);
  assign w_q_pop   = w_deq && !w_q_empty;
`else
  assign out_valid = !rst && !redirect_valid && !w_q_empty;
  assign out_inst  = w_q_empty ? INST_NOP : w_head_inst;
  assign out_pc    = w_head_pc;
  assign w_deq     = out_valid && out_ready;
  assign w_q_push  = w_rsp_keep;
  assign w_q_pop   = w_deq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still outstanding after this cycle's response is stale,
      // including responses already marked for discard.
      r_drop     <= w_inflight - CW'(w_rsp);
    end else begin
      if (w_issue)    r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_rsp_drop) r_drop     <= r_drop - CW'(1);
    end
  end

  // Addresses of accepted requests; its occupancy is the in-flight count.
  ysyx_22040125_ifq_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (1'b0),
    .i_push  (w_issue),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_rsp),
    .o_rdata (w_rsp_pc),
    .o_count (w_inflight)
  );

  ysyx_22040125_ifq_fifo #(
    .WIDTH (ILEN + XLEN),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect_valid),
    .i_push  (w_q_push),
    .i_wdata ({imem_rsp_inst, w_rsp_pc}),
    .i_pop   (w_q_pop),
    .o_rdata ({w_head_inst, w_head_pc}),
    .o_count (w_qcount)
  );

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (w_inflight == '0)));

endmodule

// File: tb/tb_ysyx_22040125_ifu_queue.sv
module tb_ysyx_22040125_ifu_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef YSYX_22040125_IFQ_BYPASS_EN
  localparam int unsigned FIRST_LAT = 1;
`else
  localparam int unsigned FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  always #5 clk = ~clk;

  ysyx_22040125_ifu_queue #(
    .XLEN     (64),
    .ILEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  typedef struct { logic [63:0] addr; int unsigned due; } mem_t;
  typedef struct { logic [63:0] pc; bit stale; } fl_t;

  // memory environment
  mem_t        mem_q[$];
  int unsigned last_due;
  // reference model: buffered pcs, outstanding requests, next fetch address
  logic [63:0] mq[$];
  fl_t         infl[$];
  logic [63:0] exp_fetch;
  // observed history
  logic [63:0] iss_q[$];
  logic [63:0] got_q[$];
  int unsigned iss_cyc[$];
  int unsigned got_cyc[$];

  int unsigned cyc, lat, rdy_pct, req_pct;
  int          n_checks, n_fail;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive, compare against the model, advance environment and model.
  task automatic cycle(input bit redir, input logic [63:0] rpc);
    bit          rsp, keep, exp_rv, exp_ov, deq;
    int unsigned live;
    logic [63:0] exp_pc, rsp_pc;
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < req_pct);
    rsp            = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_inst  = rsp ? inst_of(mem_q[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (infl[i]) if (!infl[i].stale) live++;
    exp_rv = !redir && ((mq.size() + live) < DEPTH);
    rsp_pc = '0;
    keep   = 1'b0;
    if (rsp && infl.size() != 0) begin
      rsp_pc = infl[0].pc;
      keep   = !infl[0].stale && !redir;
    end
`ifdef YSYX_22040125_IFQ_BYPASS_EN
    exp_ov = !redir && (mq.size() != 0 || keep);
`else
    exp_ov = !redir && (mq.size() != 0);
`endif
    exp_pc = (mq.size() != 0) ? mq[0] : rsp_pc;

    n_checks++;
    if (imem_req_valid !== exp_rv) begin
      n_fail++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_checks++;
      if (imem_req_addr !== exp_fetch) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_fetch);
      end
    end
    n_checks++;
    if (out_valid !== exp_ov) begin
      n_fail++;
      $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_ov);
    end
    if (exp_ov) begin
      n_checks++;
      if (out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
        n_fail++;
        $display("FAIL out_data cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                 cyc, out_pc, out_inst, exp_pc, inst_of(exp_pc));
      end
    end

    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{addr: imem_req_addr, due: last_due});
      iss_q.push_back(imem_req_addr);
      iss_cyc.push_back(cyc);
    end
    if (rsp) mem_q.delete(0);
    if (out_valid === 1'b1 && out_ready) begin
      got_q.push_back(out_pc);
      got_cyc.push_back(cyc);
    end

    deq = exp_ov && out_ready;
    if (rsp && infl.size() != 0) infl.delete(0);
    if (redir) begin
      mq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      exp_fetch = {rpc[63:2], 2'b00};
    end else begin
      if (keep) mq.push_back(rsp_pc);
      if (deq && mq.size() != 0) mq.delete(0);
    end
    if (exp_rv && imem_req_ready) begin
      infl.push_back('{pc: exp_fetch, stale: 1'b0});
      exp_fetch = exp_fetch + 64'd4;
    end
    cyc++;
  endtask

  // Two reset cycles; memory is reset together with the IFU.
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      if (i == 1) begin
        n_checks++;
        if (imem_req_addr !== RESET_PC) begin
          n_fail++;
          $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
        end
      end
      cyc++;
    end
    mem_q.delete(); infl.delete(); mq.delete();
    iss_q.delete(); got_q.delete(); iss_cyc.delete(); got_cyc.delete();
    exp_fetch = RESET_PC;
    last_due  = cyc;
  endtask

  task automatic test_reset();
    lat = 1; rdy_pct = 100; req_pct = 100;
    do_reset();
    cycle(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; rdy_pct = 100; req_pct = 100;
    for (int i = 0; i < 30; i++) cycle(1'b0, '0);
    n_checks++;
    if (got_q.size() < 20) begin
      n_fail++;
      $display("FAIL stream_count: got %0d expected >= 20", got_q.size());
    end
    n_checks++;
    if (got_cyc.size() == 0 || iss_cyc.size() == 0 || (got_cyc[0] - iss_cyc[0]) != FIRST_LAT) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d expected %0d",
               (got_cyc.size() != 0 && iss_cyc.size() != 0) ? got_cyc[0] - iss_cyc[0] : 0, FIRST_LAT);
    end
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== RESET_PC + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_q[i], RESET_PC + 64'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1; rdy_pct = 0; req_pct = 100;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);
    n_checks++;
    if (iss_q.size() != 4) begin
      n_fail++;
      $display("FAIL stall_issued: got %0d expected 4", iss_q.size());
    end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req_low: got %b expected 0", imem_req_valid);
    end
    rdy_pct = 100;
    cycle(1'b0, '0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== RESET_PC) begin
      n_fail++;
      $display("FAIL stall_pop: got n=%0d expected 1 entry at %h", got_q.size(), RESET_PC);
    end
    rdy_pct = 0;
    cycle(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 64'd16) begin
      n_fail++;
      $display("FAIL stall_resume: got valid=%b addr=%h expected 1 %h",
               imem_req_valid, imem_req_addr, RESET_PC + 64'd16);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 4; rdy_pct = 100; req_pct = 100;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0);
    cycle(1'b1, 64'h8000_0102);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0);
    n_checks++;
    if (iss_q.size() < 4 || iss_q[2] !== 64'h8000_0008 || iss_q[3] !== 64'h8000_0100) begin
      n_fail++;
      $display("FAIL redirect_addr: got %h expected %h", (iss_q.size() > 3) ? iss_q[3] : 64'h0, 64'h8000_0100);
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 64'h8000_0100) begin
      n_fail++;
      $display("FAIL redirect_first_pc: got %h expected %h", (got_q.size() != 0) ? got_q[0] : 64'h0, 64'h8000_0100);
    end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat = 2; rdy_pct = 100; req_pct = 100;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b1, 64'h8000_0200);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_rsp_out_valid: got %b expected 0", out_valid);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, '0);
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 64'h8000_0200) begin
      n_fail++;
      $display("FAIL redir_rsp_first_pc: got %h expected %h", (got_q.size() != 0) ? got_q[0] : 64'h0, 64'h8000_0200);
    end
  endtask

  task automatic test_double_redirect();
    int unsigned n_a;
    do_reset();
    lat = 5; rdy_pct = 100; req_pct = 100;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b1, 64'h8000_0400);
    cycle(1'b0, '0);
    cycle(1'b1, 64'h8000_0800);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0);
    n_checks++;
    if (iss_q.size() < 4 || iss_q[2] !== 64'h8000_0400 || iss_q[3] !== 64'h8000_0800) begin
      n_fail++;
      $display("FAIL dbl_issue: got n=%0d third=%h expected %h then %h", iss_q.size(),
               (iss_q.size() > 2) ? iss_q[2] : 64'h0, 64'h8000_0400, 64'h8000_0800);
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 64'h8000_0800) begin
      n_fail++;
      $display("FAIL dbl_first_pc: got %h expected %h", (got_q.size() != 0) ? got_q[0] : 64'h0, 64'h8000_0800);
    end
    n_a = 0;
    foreach (got_q[i]) if (got_q[i] == 64'h8000_0400) n_a++;
    n_checks++;
    if (n_a != 0) begin
      n_fail++;
      $display("FAIL dbl_stale_seen: got %0d expected 0", n_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3; rdy_pct = 0; req_pct = 100;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0);
    do_reset();
    rdy_pct = 100;
    cycle(1'b0, '0);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got req=%b addr=%h out_valid=%b expected 1 %h 0",
               imem_req_valid, imem_req_addr, out_valid, RESET_PC);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0);
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_mid_first_pc: got %h expected %h", (got_q.size() != 0) ? got_q[0] : 64'h0, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          r;
    logic [63:0] t;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        lat     = $urandom_range(1, 5);
        rdy_pct = $urandom_range(20, 100);
        req_pct = $urandom_range(30, 100);
      end
      r = ($urandom_range(99) < 4);
      if ($urandom_range(7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else                        t = {32'h8000_0000, $urandom};
      cycle(r, t);
    end
    n_checks++;
    if (got_q.size() < 200) begin
      n_fail++;
      $display("FAIL random_progress: got %0d expected >= 200", got_q.size());
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; last_due = 0;
    lat = 1; rdy_pct = 100; req_pct = 100;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_inst = '0; out_ready = 1'b0;
    exp_fetch = RESET_PC;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_double_redirect();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
